// File: rtl/risc_cpu_pkg.sv
// rtl/risc_cpu_pkg.sv - shared widths, opcodes and FSM state type for the accumulator CPU
package risc_cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_LDA = 4'b0100;
  localparam logic [3:0] OP_STA = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_CLA = 4'b1001;

  localparam logic [DATA_W-1:0] HLT_WORD = 8'h00;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  // Opcodes whose EXECUTE cycle needs M[a] as an operand.
  function automatic logic reads_mem(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_alu.sv
// rtl/risc_alu.sv - combinational accumulator update and zero flag
module risc_alu
  import risc_cpu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  assign zero = (ac == '0);

  always_comb begin
    result = ac;
    case (op)
      OP_ADD:  result = ac + operand;
      OP_SUB:  result = ac - operand;
      OP_AND:  result = ac & operand;
      OP_OR:   result = ac | operand;
      OP_LDA:  result = operand;
      OP_INC:  result = ac + 8'd1;
      OP_CLA:  result = '0;
      default: result = ac;
    endcase
  end

endmodule

// File: rtl/risc_cpu.sv
// rtl/risc_cpu.sv - two-clock FETCH/EXECUTE accumulator CPU driving a 16-byte external memory
module risc_cpu
  import risc_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] memoryOut,
  output logic [DATA_W-1:0] memoryIn,
  output logic [ADDR_W-1:0] address
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [DATA_W-1:0] ir, ir_next;
  logic [DATA_W-1:0] ac, ac_next;
  logic [DATA_W-1:0] alu_result;
  logic              ac_zero;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand_addr;

  assign opcode       = ir[7:4];
  assign operand_addr = ir[3:0];

  risc_alu u_alu (
    .op      (opcode),
    .ac      (ac),
    .operand (memoryOut),
    .result  (alu_result),
    .zero    (ac_zero)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      ac    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      ac    <= ac_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    ac_next    = ac;
    case (state)
      ST_FETCH: begin
        ir_next    = memoryOut;
        pc_next    = pc + 4'd1;
        state_next = (memoryOut == HLT_WORD) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        ac_next = alu_result;
        if ((opcode == OP_JMP) || ((opcode == OP_JZ) && ac_zero))
          pc_next = operand_addr;
        state_next = ST_FETCH;
      end
      default: ;
    endcase
  end

  // Outputs are gated by clr so a write is dropped the instant reset asserts.
  always_comb begin
    read     = 1'b0;
    write    = 1'b0;
    address  = '0;
    memoryIn = '0;
    if (clr) begin
      memoryIn = ac;
      case (state)
        ST_FETCH: begin
          address = pc;
          read    = 1'b1;
        end
        ST_EXECUTE: begin
          address = operand_addr;
          read    = reads_mem(opcode);
          write   = (opcode == OP_STA);
        end
        default: address = pc;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_cpu.sv
// tb/tb_risc_cpu.sv - self-checking bench for risc_cpu with memory model and ISA reference
module tb_risc_cpu;
  import risc_cpu_pkg::*;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       read, write;
  logic [7:0] memoryOut, memoryIn;
  logic [3:0] address;

  logic [7:0]       mem [16];
  logic [15:0][7:0] load_img = '0;
  logic             load_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  risc_cpu dut (
    .clk       (clk),
    .clr       (clr),
    .read      (read),
    .write     (write),
    .memoryOut (memoryOut),
    .memoryIn  (memoryIn),
    .address   (address)
  );

  always #5 clk = ~clk;

  assign memoryOut = mem[address];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 16; i++) mem[i] <= load_img[i];
    end else if (write) begin
      mem[address] <= memoryIn;
    end
  end

  typedef struct packed {
    logic [15:0][7:0] prog;
    logic [7:0]       cycles;
    logic [3:0]       addr;
    logic [7:0]       exp_val;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic start(input logic [15:0][7:0] img);
    clr = 1'b0;
    load_img = img;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic setb(input int v, input int a, input logic [7:0] w);
    vecs[v].prog[a] = w;
  endtask

  logic [7:0] m_mem [16];
  logic [3:0] m_pc;
  logic [7:0] m_ac;
  bit         m_halt;

  // Instruction-level interpreter: each instruction costs two clocks, HLT costs one.
  task automatic model_run(input logic [15:0][7:0] img, input int cycles);
    int left;
    logic [7:0] w;
    int a;
    for (int i = 0; i < 16; i++) m_mem[i] = img[i];
    m_pc = 4'd0;
    m_ac = 8'd0;
    m_halt = 1'b0;
    left = cycles;
    while (left > 0 && !m_halt) begin
      w = m_mem[m_pc];
      m_pc = m_pc + 4'd1;
      left--;
      if (w == 8'h00) begin
        m_halt = 1'b1;
      end else if (left > 0) begin
        a = int'(w[3:0]);
        case (w[7:4])
          4'h0: m_ac = m_ac + m_mem[a];
          4'h1: m_ac = m_ac - m_mem[a];
          4'h2: m_ac = m_ac & m_mem[a];
          4'h3: m_ac = m_ac | m_mem[a];
          4'h4: m_ac = m_mem[a];
          4'h5: m_mem[a] = m_ac;
          4'h6: m_pc = w[3:0];
          4'h7: if (m_ac == 8'h00) m_pc = w[3:0];
          4'h8: m_ac = m_ac + 8'd1;
          4'h9: m_ac = 8'h00;
          default: ;
        endcase
        left--;
      end
    end
  endtask

  initial begin
    logic [15:0][7:0] img;
    int n_w;
    int w_k [2];
    logic [3:0] w_a [2];
    logic [7:0] w_d [2];
    int busy;
    int cyc;

    for (int v = 0; v < 7; v++) vecs[v] = '0;
    setb(0, 0, 8'h47); setb(0, 1, 8'h06); setb(0, 2, 8'h54); setb(0, 6, 8'h02); setb(0, 7, 8'h03);
    vecs[0].cycles = 8'd6; vecs[0].addr = 4'h4; vecs[0].exp_val = 8'h05;
    setb(1, 0, 8'h4A); setb(1, 1, 8'h0B); setb(1, 2, 8'h5C); setb(1, 10, 8'hFF); setb(1, 11, 8'h02);
    vecs[1].cycles = 8'd6; vecs[1].addr = 4'hC; vecs[1].exp_val = 8'h01;
    setb(2, 0, 8'h4A); setb(2, 1, 8'h1B); setb(2, 2, 8'h5C); setb(2, 10, 8'h02); setb(2, 11, 8'h03);
    vecs[2].cycles = 8'd6; vecs[2].addr = 4'hC; vecs[2].exp_val = 8'hFF;
    for (int v = 3; v < 5; v++) begin
      setb(v, 0, 8'h4A); setb(v, 1, 8'h75); setb(v, 2, 8'h80); setb(v, 3, 8'h59);
      setb(v, 5, 8'h80); setb(v, 6, 8'h59); setb(v, 9, 8'hEE);
      vecs[v].cycles = 8'd8; vecs[v].addr = 4'h9;
    end
    setb(4, 10, 8'h05);
    vecs[3].exp_val = 8'h01;
    vecs[4].exp_val = 8'h06;
    for (int v = 5; v < 7; v++) begin
      setb(v, 0, 8'h4A); setb(v, 1, 8'h2B); setb(v, 2, 8'h5C); setb(v, 3, 8'h3D); setb(v, 4, 8'h5E);
      setb(v, 10, 8'hF0); setb(v, 11, 8'h3C); setb(v, 13, 8'h0F);
      vecs[v].cycles = 8'd10;
    end
    vecs[5].addr = 4'hC; vecs[5].exp_val = 8'h30;
    vecs[6].addr = 4'hE; vecs[6].exp_val = 8'h3F;

    // Reset state
    clr = 1'b0;
    load_img = vecs[0].prog;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check("rst_read", 8'(read), 8'h00);
    check("rst_write", 8'(write), 8'h00);
    check("rst_address", 8'(address), 8'h00);
    check("rst_memin", memoryIn, 8'h00);
    check("rst_pc", 8'(dut.pc), 8'h00);
    check("rst_ac", dut.ac, 8'h00);
    check("rst_ir", dut.ir, 8'h00);
    check("rst_state", 8'(dut.state), 8'(ST_FETCH));

    // Table-driven programs
    for (int v = 0; v < 7; v++) begin
      start(vecs[v].prog);
      repeat (int'(vecs[v].cycles)) @(negedge clk);
      check($sformatf("vec%0d_M[%h]", v, vecs[v].addr), mem[vecs[v].addr], vecs[v].exp_val);
    end

    // Add program: write lands exactly at clock 6, then halt and stay quiet
    start(vecs[0].prog);
    repeat (5) @(negedge clk);
    check("add_M4_before_clk6", mem[4], 8'h00);
    @(negedge clk);
    check("add_M4_at_clk6", mem[4], 8'h05);
    @(negedge clk);
    check("add_halted", 8'(dut.state), 8'(ST_HALT));
    busy = 0;
    for (int k = 0; k < 50; k++) begin
      if (read || write) busy++;
      @(negedge clk);
    end
    check("halt_quiet_cycles", 8'(busy), 8'h00);
    check("halt_M4_kept", mem[4], 8'h05);

    // Write strobe: one clock per STA with the right address and data
    start(vecs[5].prog);
    n_w = 0;
    for (int k = 1; k <= 12; k++) begin
      if (write) begin
        if (n_w < 2) begin
          w_k[n_w] = k; w_a[n_w] = address; w_d[n_w] = memoryIn;
        end
        n_w++;
      end
      @(negedge clk);
    end
    check("sta_write_count", 8'(n_w), 8'd2);
    if (n_w >= 2) begin
      check("sta0_clock", 8'(w_k[0]), 8'd6);
      check("sta0_addr", 8'(w_a[0]), 8'h0C);
      check("sta0_data", w_d[0], 8'h30);
      check("sta1_clock", 8'(w_k[1]), 8'd10);
      check("sta1_addr", 8'(w_a[1]), 8'h0E);
      check("sta1_data", w_d[1], 8'h3F);
    end

    // Async reset in the middle of the STA execute cycle
    start(vecs[0].prog);
    repeat (5) @(negedge clk);
    check("midsta_write_before", 8'(write), 8'h01);
    check("midsta_addr_before", 8'(address), 8'h04);
    check("midsta_data_before", memoryIn, 8'h05);
    #2 clr = 1'b0;
    #1;
    check("midsta_write_drop", 8'(write), 8'h00);
    check("midsta_read_drop", 8'(read), 8'h00);
    check("midsta_addr_zero", 8'(address), 8'h00);
    check("midsta_memin_zero", memoryIn, 8'h00);
    check("midsta_pc", 8'(dut.pc), 8'h00);
    check("midsta_ac", dut.ac, 8'h00);
    check("midsta_ir", dut.ir, 8'h00);
    @(negedge clk);
    check("midsta_no_store", mem[4], 8'h00);
    clr = 1'b1;
    repeat (6) @(negedge clk);
    check("midsta_restart_store", mem[4], 8'h05);

    // PC wrap with a HLT-free program
    img = '0;
    for (int i = 1; i < 16; i++) img[i] = 8'hA0 + 8'(i);
    img[0] = 8'h80;
    start(img);
    repeat (30) @(negedge clk);
    check("wrap_pc15", 8'(dut.pc), 8'h0F);
    repeat (2) @(negedge clk);
    check("wrap_pc0", 8'(dut.pc), 8'h00);
    check("wrap_ac1", dut.ac, 8'h01);
    repeat (2) @(negedge clk);
    check("wrap_pc1", 8'(dut.pc), 8'h01);
    check("wrap_ir", dut.ir, 8'h80);
    check("wrap_ac2", dut.ac, 8'h02);

    // Random programs against the instruction-level model
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 16; i++)
        img[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cyc = 2 * int'($urandom_range(1, 20));
      start(img);
      repeat (cyc) @(negedge clk);
      model_run(img, cyc);
      for (int i = 0; i < 16; i++)
        check($sformatf("rnd%0d_M[%0d]", t, i), mem[i], m_mem[i]);
      check($sformatf("rnd%0d_pc", t), 8'(dut.pc), 8'(m_pc));
      check($sformatf("rnd%0d_ac", t), dut.ac, m_ac);
      check($sformatf("rnd%0d_halt", t), 8'(dut.state == ST_HALT), 8'(m_halt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
